// File: rtl/riscv_data_mem_responder_pkg.sv
// rtl/riscv_data_mem_responder_pkg.sv - shared definitions for the data memory responder
// Purpose: atop codes, stall FSM state type, address range and atop decode helpers.
// Optional feature macro: RISCV_DATA_RESP_AMO_EN (selects which atop codes are accepted).
package riscv_data_resp_pkg;

   localparam logic [5:0] ATOP_SWAP = 6'b110000;
   localparam logic [5:0] ATOP_ADD  = 6'b100000;
   localparam logic [5:0] ATOP_CLR  = 6'b100001;
   localparam logic [5:0] ATOP_EOR  = 6'b100010;
   localparam logic [5:0] ATOP_SET  = 6'b100011;
   localparam logic [5:0] ATOP_SMAX = 6'b100100;
   localparam logic [5:0] ATOP_SMIN = 6'b100101;
   localparam logic [5:0] ATOP_UMAX = 6'b100110;
   localparam logic [5:0] ATOP_UMIN = 6'b100111;

   typedef enum logic {
      ST_IDLE,
      ST_STALL
   } stall_state_e;

   // The offset compare avoids overflowing base + span at the top of the address map.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] span);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && (off < span);
   endfunction

   function automatic logic atop_is_amo(input logic [5:0] atop);
      logic hit;
      case (atop)
         ATOP_SWAP, ATOP_ADD, ATOP_CLR, ATOP_EOR, ATOP_SET,
         ATOP_SMAX, ATOP_SMIN, ATOP_UMAX, ATOP_UMIN: hit = 1'b1;
         default:                                     hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/riscv_data_mem_responder_if.sv
// rtl/riscv_data_mem_responder_if.sv - data memory request/response bus
// Purpose: bundles the core data memory protocol (req/gnt/rvalid/err, be, atop).
// Ports: master drives req/addr/we/be/wdata/atop; slave drives gnt/rvalid/err/rdata.
interface riscv_data_mem_responder_if;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic [5:0]  data_atop_i;

   modport master (
      output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
      input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
   );

   modport slave (
      input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
      output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
   );
endinterface

// File: rtl/riscv_data_mem_responder_amo_alu.sv
// rtl/riscv_data_mem_responder_amo_alu.sv - atomic read-modify-write datapath
// Purpose: computes the new memory word for an AMO from the old word and the operand.
// Ports: old (current word), operand (store data), atop (code) -> result (word to write).
// Compiled only when RISCV_DATA_RESP_AMO_EN is defined.
`ifdef RISCV_DATA_RESP_AMO_EN
module riscv_amo_alu
   import riscv_data_resp_pkg::*;
(
   input  logic [31:0] old,
   input  logic [31:0] operand,
   input  logic [5:0]  atop,
   output logic [31:0] result
);

   always_comb begin
      result = old;
      case (atop)
         ATOP_SWAP: result = operand;
         ATOP_ADD:  result = old + operand;
         ATOP_CLR:  result = old & ~operand;
         ATOP_EOR:  result = old ^ operand;
         ATOP_SET:  result = old | operand;
         ATOP_SMAX: result = ($signed(old) > $signed(operand)) ? old : operand;
         ATOP_SMIN: result = ($signed(old) < $signed(operand)) ? old : operand;
         ATOP_UMAX: result = (old > operand) ? old : operand;
         ATOP_UMIN: result = (old < operand) ? old : operand;
         default:   result = old;
      endcase
   end

endmodule
`endif

// File: rtl/riscv_data_mem_responder.sv
// rtl/riscv_data_mem_responder.sv - single-bank data memory responder
// Purpose: grants data requests after GNT_STALL eligible cycles, performs the access in the
//   grant cycle and returns the pre-write word RESP_LATENCY cycles later.
// Ports: clk_i, rst_ni (async active-low), bus (slave side of riscv_data_mem_responder_if).
// Optional feature: RISCV_DATA_RESP_AMO_EN enables atomic read-modify-write atop codes.
module riscv_data_mem_responder
   import riscv_data_resp_pkg::*;
#(
   parameter int          NUM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
   parameter int          RESP_LATENCY = 1,
   parameter int          GNT_STALL    = 0
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   riscv_data_mem_responder_if.slave    bus
);

   localparam int          IDX_W     = $clog2(NUM_WORDS);
   localparam logic [31:0] SPAN      = 32'(NUM_WORDS * 4);
   localparam logic [3:0]  STALL_MAX = 4'(GNT_STALL);
   localparam logic [2:0]  LAT_LOAD  = 3'(RESP_LATENCY);

   logic [31:0]      mem [NUM_WORDS];
   stall_state_e     state, state_nxt;
   logic [3:0]       stall_cnt, stall_cnt_nxt;
   logic             outstanding;
   logic [2:0]       lat_cnt;
   logic [31:0]      resp_q, rdata_hold;
   logic             rvalid, eligible, in_range, atop_ok, err, gnt, wr_en;
   logic [31:0]      off, old_word, wr_word;
   logic [IDX_W-1:0] idx;

   assign rvalid   = outstanding && (lat_cnt == 3'd1);
   // A response retiring this cycle frees the slot, so a new grant may overlap it.
   assign eligible = bus.data_req_i && (!outstanding || rvalid);
   assign in_range = addr_in_range(bus.data_addr_i, BASE_ADDR, SPAN);
   assign err      = eligible && !(in_range && atop_ok);
   assign off      = bus.data_addr_i - BASE_ADDR;
   assign idx      = IDX_W'(off >> 2);
   assign old_word = mem[idx];

`ifdef RISCV_DATA_RESP_AMO_EN
   logic        is_amo;
   logic [31:0] amo_new;

   assign is_amo  = (bus.data_atop_i != 6'd0);
   assign atop_ok = !is_amo || atop_is_amo(bus.data_atop_i);
   assign wr_en   = gnt && (bus.data_we_i || is_amo);

   riscv_amo_alu u_amo_alu (
      .old     (old_word),
      .operand (bus.data_wdata_i),
      .atop    (bus.data_atop_i),
      .result  (amo_new)
   );
`else
   assign atop_ok = (bus.data_atop_i == 6'd0);
   assign wr_en   = gnt && bus.data_we_i;
`endif

   always_comb begin
      wr_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (bus.data_be_i[i]) wr_word[8*i +: 8] = bus.data_wdata_i[8*i +: 8];
      end
`ifdef RISCV_DATA_RESP_AMO_EN
      // AMOs always rewrite the full word regardless of byte enables.
      if (is_amo) wr_word = amo_new;
`endif
   end

   // Stall FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         stall_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   // Stall FSM: next state. A held request blocked by an outstanding response keeps its count.
   always_comb begin
      state_nxt     = state;
      stall_cnt_nxt = stall_cnt;
      if (!bus.data_req_i || err || gnt) begin
         state_nxt     = ST_IDLE;
         stall_cnt_nxt = 4'd0;
      end else if (eligible) begin
         state_nxt     = ST_STALL;
         stall_cnt_nxt = stall_cnt + 4'd1;
      end
   end

   // Stall FSM: outputs
   always_comb begin
      gnt = 1'b0;
      if (eligible && !err) begin
         if (state == ST_IDLE) gnt = (STALL_MAX == 4'd0);
         else                  gnt = (stall_cnt == STALL_MAX);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= 1'b0;
         lat_cnt     <= 3'd0;
         resp_q      <= 32'd0;
         rdata_hold  <= 32'd0;
      end else begin
         if (rvalid) rdata_hold <= resp_q;
         if (gnt) begin
            outstanding <= 1'b1;
            lat_cnt     <= LAT_LOAD;
            resp_q      <= old_word;
         end else if (outstanding) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) outstanding <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[idx] <= wr_word;
   end

   assign bus.data_gnt_o    = gnt;
   assign bus.data_rvalid_o = rvalid;
   assign bus.data_err_o    = err;
   assign bus.data_rdata_o  = rvalid ? resp_q : rdata_hold;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// tb/tb_riscv_data_mem_responder.sv - bench for riscv_data_mem_responder
// Purpose: two responder configurations (no stall / latency 1, stall 3 / latency 2) driven
//   with directed and random traffic and compared every cycle against a behavioural model.
// Optional feature: RISCV_DATA_RESP_AMO_EN adds AMO stimulus and model support.
module tb_riscv_data_mem_responder;

   localparam int          NW   = 16;
   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int          ST0 = 0, LAT0 = 1, ST1 = 3, LAT1 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscv_data_mem_responder_if if_a ();
   riscv_data_mem_responder_if if_b ();

   logic [1:0]  req, we;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0]  be [2];
   logic [5:0]  atop [2];
   logic [1:0]  gnt_w, rv_w, err_w;
   logic [31:0] rd_w [2];

   assign if_a.data_req_i = req[0];   assign if_b.data_req_i = req[1];
   assign if_a.data_addr_i = addr[0]; assign if_b.data_addr_i = addr[1];
   assign if_a.data_we_i = we[0];     assign if_b.data_we_i = we[1];
   assign if_a.data_be_i = be[0];     assign if_b.data_be_i = be[1];
   assign if_a.data_wdata_i = wdata[0]; assign if_b.data_wdata_i = wdata[1];
   assign if_a.data_atop_i = atop[0]; assign if_b.data_atop_i = atop[1];
   assign gnt_w = {if_b.data_gnt_o, if_a.data_gnt_o};
   assign rv_w  = {if_b.data_rvalid_o, if_a.data_rvalid_o};
   assign err_w = {if_b.data_err_o, if_a.data_err_o};
   assign rd_w[0] = if_a.data_rdata_o;
   assign rd_w[1] = if_b.data_rdata_o;

   riscv_data_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .RESP_LATENCY(LAT0), .GNT_STALL(ST0))
      dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave));
   riscv_data_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .RESP_LATENCY(LAT1), .GNT_STALL(ST1))
      dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave));

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: memory image, per-word "known" flag, pending response with due cycle.
   logic [31:0] m_mem [2][NW];
   bit          m_kn [2][NW];
   bit          m_pend [2];
   int          m_due [2];
   logic [31:0] m_pdata [2];
   bit          m_pkn [2];
   logic [31:0] m_last [2];
   bit          m_lkn [2];
   int          m_streak [2];
   int          cyc = 0;

`ifdef RISCV_DATA_RESP_AMO_EN
   localparam logic [5:0] AMO_CODES [9] = '{6'b110000, 6'b100000, 6'b100001, 6'b100010,
                                            6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
   function automatic logic [31:0] amo_calc(input logic [5:0] a, input logic [31:0] o,
                                            input logic [31:0] p);
      case (a)
         6'b110000: return p;
         6'b100000: return o + p;
         6'b100001: return o & ~p;
         6'b100010: return o ^ p;
         6'b100011: return o | p;
         6'b100100: return ($signed(o) > $signed(p)) ? o : p;
         6'b100101: return ($signed(o) < $signed(p)) ? o : p;
         6'b100110: return (o > p) ? o : p;
         6'b100111: return (o < p) ? o : p;
         default:   return o;
      endcase
   endfunction
`endif

   function automatic bit atop_ok(input logic [5:0] a);
      if (a == 6'd0) return 1'b1;
`ifdef RISCV_DATA_RESP_AMO_EN
      for (int i = 0; i < 9; i++) if (AMO_CODES[i] == a) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic int stall_of(input int k); return (k == 0) ? ST0 : ST1; endfunction
   function automatic int lat_of(input int k);   return (k == 0) ? LAT0 : LAT1; endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      cyc++;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_pend[k] = 1'b0; m_streak[k] = 0; m_last[k] = 32'd0; m_lkn[k] = 1'b1;
         end
         return;
      end
      for (int k = 0; k < 2; k++) begin
         bit rv, el, ok, e_err, e_gnt;
         int w;
         logic [31:0] old, nw;
         rv    = m_pend[k] && (m_due[k] == cyc);
         el    = req[k] && (!m_pend[k] || rv);
         ok    = (addr[k] >= BASE) && (addr[k] < BASE + 32'(NW * 4)) && atop_ok(atop[k]);
         e_err = el && !ok;
         e_gnt = el && ok && (m_streak[k] == stall_of(k));
         chk($sformatf("gnt[%0d]", k), 32'(gnt_w[k]), 32'(e_gnt));
         chk($sformatf("err[%0d]", k), 32'(err_w[k]), 32'(e_err));
         chk($sformatf("rvalid[%0d]", k), 32'(rv_w[k]), 32'(rv));
         if (rv ? m_pkn[k] : m_lkn[k])
            chk($sformatf("rdata[%0d]", k), rd_w[k], rv ? m_pdata[k] : m_last[k]);
         if (rv) begin
            m_pend[k] = 1'b0; m_last[k] = m_pdata[k]; m_lkn[k] = m_pkn[k];
         end
         if (!req[k] || e_err || e_gnt) m_streak[k] = 0;
         else if (el) m_streak[k]++;
         if (e_gnt) begin
            w   = int'((addr[k] - BASE) >> 2);
            old = m_mem[k][w];
            nw  = old;
            if (we[k]) for (int i = 0; i < 4; i++) if (be[k][i]) nw[8*i +: 8] = wdata[k][8*i +: 8];
`ifdef RISCV_DATA_RESP_AMO_EN
            if (atop[k] != 6'd0) nw = amo_calc(atop[k], old, wdata[k]);
`endif
            m_pdata[k] = old;
            m_pkn[k]   = m_kn[k][w];
            m_mem[k][w] = nw;
            m_kn[k][w] = m_kn[k][w] || (we[k] && be[k] == 4'hF && atop[k] == 6'd0)
                         || (atop[k] == 6'b110000);
            m_pend[k]  = 1'b1;
            m_due[k]   = cyc + lat_of(k);
         end
      end
   endtask

   task automatic access(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [5:0] at, output int waited);
      bit done;
      req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d; atop[k] = at;
      waited = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (gnt_w[k]) done = 1'b1;
         else begin
            waited++;
            if (waited > 40) begin
               chk($sformatf("gnt_timeout[%0d]", k), 32'(gnt_w[k]), 32'd1);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      req[k] = 1'b0; we[k] = 1'b0; atop[k] = 6'd0;
   endtask

   task automatic wait_rv(input int k, output logic [31:0] d, output int lat);
      bit done;
      lat = 0; done = 1'b0; d = 32'd0;
      while (!done) begin
         @(negedge clk);
         lat++;
         if (rv_w[k]) begin d = rd_w[k]; done = 1'b1; end
         else if (lat > 20) begin
            chk($sformatf("rvalid_timeout[%0d]", k), 32'(rv_w[k]), 32'd1);
            done = 1'b1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic reject(input logic [31:0] a, input logic w, input logic [5:0] at, input string nm);
      req[0] = 1'b1; addr[0] = a; we[0] = w; be[0] = 4'hF; wdata[0] = 32'd0; atop[0] = at;
      @(negedge clk);
      chk({nm, "_err"}, 32'(err_w[0]), 32'd1);
      chk({nm, "_gnt"}, 32'(gnt_w[0]), 32'd0);
      @(posedge clk); #1;
      req[0] = 1'b0; we[0] = 1'b0; atop[0] = 6'd0;
      @(negedge clk);
      chk({nm, "_no_rvalid"}, 32'(rv_w[0]), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int g, l, r;
      logic [31:0] d;
      req = 2'b00; we = 2'b00;
      for (int k = 0; k < 2; k++) begin
         addr[k] = BASE; wdata[k] = 32'd0; be[k] = 4'h0; atop[k] = 6'd0;
         for (int i = 0; i < NW; i++) begin m_mem[k][i] = 32'd0; m_kn[k][i] = 1'b0; end
         m_pend[k] = 1'b0; m_due[k] = 0; m_pdata[k] = 32'd0; m_pkn[k] = 1'b0;
         m_last[k] = 32'd0; m_lkn[k] = 1'b1; m_streak[k] = 0;
      end
      fork
         forever begin @(negedge clk); model_step(); end
      join_none

      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_gnt[%0d]", k), 32'(gnt_w[k]), 32'd0);
         chk($sformatf("reset_rvalid[%0d]", k), 32'(rv_w[k]), 32'd0);
         chk($sformatf("reset_err[%0d]", k), 32'(err_w[k]), 32'd0);
         chk($sformatf("reset_rdata[%0d]", k), rd_w[k], 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NW; i++)
            access(k, BASE + 32'(4 * i), 1'b1, 4'hF, 32'hA500_0000 | 32'(i), 6'd0, g);
      repeat (4) begin @(posedge clk); #1; end

      // Full store then load, byte-lane store then load on the zero-stall instance.
      access(0, 32'h0010_0004, 1'b1, 4'hF, 32'hDEAD_BEEF, 6'd0, g);
      chk("st_gnt_same_cycle", 32'(g), 32'd0);
      access(0, 32'h0010_0004, 1'b0, 4'hF, 32'd0, 6'd0, g);
      chk("ld_gnt_same_cycle", 32'(g), 32'd0);
      wait_rv(0, d, l);
      chk("ld_latency", 32'(l), 32'd1);
      chk("ld_rdata", d, 32'hDEAD_BEEF);
      access(0, 32'h0010_0004, 1'b1, 4'b0010, 32'h0000_AA00, 6'd0, g);
      access(0, 32'h0010_0004, 1'b0, 4'hF, 32'd0, 6'd0, g);
      wait_rv(0, d, l);
      chk("be_merge_rdata", d, 32'hDEAD_AAEF);

      // Stall 3, latency 2 instance.
      access(1, BASE + 32'd8, 1'b1, 4'hF, 32'h1234_5678, 6'd0, g);
      chk("stall_st_wait", 32'(g), 32'd3);
      wait_rv(1, d, l);
      chk("stall_st_latency", 32'(l), 32'd2);
      chk("stall_st_old_word", d, 32'hA500_0002);
      access(1, BASE + 32'd8, 1'b0, 4'hF, 32'd0, 6'd0, g);
      chk("stall_ld_wait", 32'(g), 32'd3);
      wait_rv(1, d, l);
      chk("stall_ld_latency", 32'(l), 32'd2);
      chk("stall_ld_rdata", d, 32'h1234_5678);
      repeat (4) begin
         @(negedge clk);
         chk("stall_no_second_rvalid", 32'(rv_w[1]), 32'd0);
         @(posedge clk); #1;
      end

      // Rejections leave memory untouched.
      reject(32'h000F_FFFC, 1'b0, 6'd0, "below_base");
      reject(BASE + 32'(NW * 4), 1'b1, 6'd0, "above_top");
      reject(BASE, 1'b1, 6'b000001, "bad_atop");
      access(0, BASE, 1'b0, 4'hF, 32'd0, 6'd0, g);
      wait_rv(0, d, l);
      chk("mem_unchanged", d, 32'hA500_0000);

      // Back-to-back loads: each gnt overlaps the previous rvalid.
      req[0] = 1'b1; we[0] = 1'b0;
      for (int j = 0; j < 4; j++) begin
         addr[0] = BASE + 32'(4 * (5 + j));
         @(negedge clk);
         chk("b2b_gnt", 32'(gnt_w[0]), 32'd1);
         if (j > 0) begin
            chk("b2b_rvalid", 32'(rv_w[0]), 32'd1);
            chk("b2b_rdata", rd_w[0], 32'hA500_0000 | 32'(4 + j));
         end
         @(posedge clk); #1;
      end
      req[0] = 1'b0;
      @(negedge clk);
      chk("b2b_last_rdata", rd_w[0], 32'hA500_0008);
      @(posedge clk); #1;

`ifdef RISCV_DATA_RESP_AMO_EN
      access(0, BASE + 32'd36, 1'b1, 4'hF, 32'd5, 6'd0, g);
      access(0, BASE + 32'd36, 1'b1, 4'h0, 32'd3, 6'b100000, g);
      wait_rv(0, d, l);
      chk("amo_add_old", d, 32'd5);
      access(0, BASE + 32'd36, 1'b0, 4'hF, 32'd0, 6'd0, g);
      wait_rv(0, d, l);
      chk("amo_add_new", d, 32'd8);
      access(0, BASE + 32'd36, 1'b1, 4'hF, 32'hFFFF_FFFF, 6'b100111, g);
      wait_rv(0, d, l);
      chk("amo_umin_old", d, 32'd8);
      access(0, BASE + 32'd36, 1'b0, 4'hF, 32'd0, 6'd0, g);
      wait_rv(0, d, l);
      chk("amo_umin_new", d, 32'd8);
`endif

      // Random traffic; the model checks every cycle.
      repeat (800) begin
         for (int k = 0; k < 2; k++) begin
            req[k] = ($urandom % 10) < 7;
            r = int'($urandom % 10);
            if (r < 8)       addr[k] = BASE + 32'(4 * ($urandom % NW)) + ($urandom % 4);
            else if (r == 8) addr[k] = ($urandom % 2 == 0) ? BASE - 32'd4 : BASE + 32'(NW * 4);
            else             addr[k] = $urandom;
            we[k] = 1'($urandom); be[k] = 4'($urandom); wdata[k] = $urandom;
            r = int'($urandom % 20);
            atop[k] = 6'd0;
            if (r == 0) atop[k] = 6'($urandom);
`ifdef RISCV_DATA_RESP_AMO_EN
            else if (r < 4) atop[k] = AMO_CODES[$urandom % 9];
`endif
         end
         @(posedge clk); #1;
      end
      req = 2'b00; we = 2'b00; atop[0] = 6'd0; atop[1] = 6'd0;
      repeat (10) begin @(posedge clk); #1; end

      // Reset while a response is pending on the latency-2 instance.
      access(1, BASE + 32'd8, 1'b0, 4'hF, 32'd0, 6'd0, g);
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("reset_drops_rvalid", 32'(rv_w[1]), 32'd0);
         chk("reset_rdata_cleared", rd_w[1], 32'd0);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
